io_reg_seq: RTL and testbench
=============================

Name: io_reg_seq

Overview:
- Sequencer/arbiter that shares one bank of rg_md-style 8-bit I/O registers between two requesters: rq0 (CPU I/O path) and rq1 (debug/aux).
- Bank registers take a write strobe (`wbe`) and a toggle strobe (`tog`) and return their current value combinationally.
- Executes READ, WRITE, TOGGLE and single-bit SET/CLEAR (read-modify-write) operations, one transaction at a time.
- Drives the bank's address, write data and strobes.

Parameters:
- P_AW, 6, bank address width (64 I/O registers).
- P_RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority with rq0 highest.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- rqN_req  in  1  request, N = 0,1; held high until rqN_ack.
- rqN_op  in  3  opcode: 000 READ, 001 WRITE, 010 TOGGLE, 011 SETB, 100 CLRB, 101-111 reserved.
- rqN_addr  in  P_AW  target register.
- rqN_wdata  in  8  write data / toggle mask; bits [2:0] give the bit index for SETB/CLRB.
- rqN_ack  out  1  one-cycle completion pulse.
- rqN_rdata  out  8  register value before the operation; valid while rqN_ack is high, held until the next ack to that requester.
- busy  out  1  high in any state other than IDLE.
- bank_addr  out  P_AW  register select.
- bank_wdata  out  8  data to the bank.
- bank_wbe  out  1  write strobe.
- bank_tog  out  1  toggle strobe; each 1 in bank_wdata inverts that bit.
- bank_rdata  in  8  current value of the selected register (combinational).

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; all outputs go to 0, including rqN_rdata and bank_addr.
  - Round-robin pointer set so rq0 wins the next tie.
  - Any in-flight transaction is abandoned: no ack is issued and no bank strobe is driven.
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - If any rqN_req=1, arbitrate; latch the grant, op, addr and wdata of the winner; go to RD.
  - Otherwise stay in IDLE.
- RD:
  - bank_addr equals the latched address.
  - Capture bank_rdata into old_q.
  - READ and reserved ops go to RESP; all other ops go to WR.
- WR (exactly one cycle; bank_addr still equals the latched address):
  - WRITE: bank_wbe=1, bank_wdata=wdata.
  - TOGGLE: bank_tog=1, bank_wdata=wdata.
  - SETB: bank_wbe=1, bank_wdata = old_q | (1<<wdata[2:0]).
  - CLRB: bank_wbe=1, bank_wdata = old_q & ~(1<<wdata[2:0]).
  - Next state RESP.
- RESP: granted rqN_ack=1 and rqN_rdata=old_q; next state IDLE. A new grant cannot occur in this cycle.
- Latency, with request sampled in IDLE at cycle t:
  - READ/reserved: ack at t+2.
  - Write-class ops: strobe at t+2, ack at t+3.
  - Minimum spacing between acks: 3 cycles for reads, 4 for writes.
- Strobe and ack rules:
  - bank_wbe and bank_tog are never high together.
  - Both are 0 outside WR.
  - bank_wdata is 0 whenever neither strobe is high.
  - Only the granted requester ever sees ack; rq0_ack and rq1_ack are never high in the same cycle.
- Arbitration:
  - P_RR=1: on a simultaneous request, grant the requester that did not win last; the pointer updates on every grant.
  - P_RR=0: rq0 always wins a tie.
  - A single requester is granted immediately, regardless of the pointer.
- Boundary cases:
  - Request inputs are latched at grant; changing rqN_* after grant has no effect.
  - If rqN_req drops before ack, the transaction still completes and acks (protocol violation, tolerated).
  - A requester holding req high after its ack is treated as a new request at the next IDLE.
  - Bit index uses only wdata[2:0]; wdata[7:3] is ignored for SETB/CLRB.
  - Reserved opcodes never strobe the bank.

Test Plan:
- Reset, then rq0 READ addr 5 with the bank holding 0xA5:
  - rq0_ack at t+2 with rq0_rdata=0xA5.
  - No strobe; busy high for cycles t+1..t+2.
- rq1 WRITE 0x3C to addr 0x10: single bank_wbe pulse at t+2 with bank_addr=0x10 and bank_wdata=0x3C; rq1_ack at t+3.
- SETB bit 6 on a register holding 0x01: wbe at t+2 with wdata=0x41. CLRB bit 0 on 0x41: wdata=0x40. rdata returns the old value in both cases.
- TOGGLE mask 0x81: bank_tog=1, bank_wdata=0x81, bank_wbe=0.
- Both req high continuously with P_RR=1:
  - Grants alternate rq0, rq1, rq0, ...; acks are never simultaneous.
  - Repeat with P_RR=0: rq0 is served every time while it holds req.
- Assert rst during WR of a SETB:
  - Next cycle: IDLE, all outputs 0, no ack.
  - A subsequent rq1 request is granted normally.

Source files
------------

// File: rtl/io_reg_seq.sv
// Sequencer/arbiter sharing one bank of 8-bit I/O registers between two requesters.
// Each transaction reads the old value, optionally strobes the bank once, then acks.
module io_reg_seq #(
  parameter int P_AW = 6,
  parameter bit P_RR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rq0_req,
  input  logic [2:0]      rq0_op,
  input  logic [P_AW-1:0] rq0_addr,
  input  logic [7:0]      rq0_wdata,
  output logic            rq0_ack,
  output logic [7:0]      rq0_rdata,
  input  logic            rq1_req,
  input  logic [2:0]      rq1_op,
  input  logic [P_AW-1:0] rq1_addr,
  input  logic [7:0]      rq1_wdata,
  output logic            rq1_ack,
  output logic [7:0]      rq1_rdata,
  output logic            busy,
  output logic [P_AW-1:0] bank_addr,
  output logic [7:0]      bank_wdata,
  output logic            bank_wbe,
  output logic            bank_tog,
  input  logic [7:0]      bank_rdata
);

  localparam logic [2:0] OP_WRITE  = 3'd1;
  localparam logic [2:0] OP_TOGGLE = 3'd2;
  localparam logic [2:0] OP_SETB   = 3'd3;
  localparam logic [2:0] OP_CLRB   = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t     r_state;
  logic       r_gnt;
  logic       r_last;
  logic [2:0] r_op;
  logic [7:0] r_wdata;
  logic [7:0] r_old_q;

  logic       w_gnt;
  logic       w_is_wr;
  logic [7:0] w_mask;

  function automatic logic [7:0] f_wr_data(input logic [2:0] op, input logic [7:0] wdata,
                                           input logic [7:0] old_q, input logic [7:0] mask);
    case (op)
      OP_SETB: f_wr_data = old_q | mask;
      OP_CLRB: f_wr_data = old_q & ~mask;
      default: f_wr_data = wdata;
    endcase
  endfunction

  // Tie goes to the requester that lost last time in round-robin mode, else to rq0.
  always_comb begin
    w_gnt = rq1_req;
    if (rq0_req && rq1_req) w_gnt = P_RR ? ~r_last : 1'b0;
  end

  assign w_is_wr = (r_op == OP_WRITE) || (r_op == OP_TOGGLE) ||
                   (r_op == OP_SETB)  || (r_op == OP_CLRB);
  assign w_mask  = 8'h01 << r_wdata[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= 1'b0;
      r_last     <= 1'b1;
      busy       <= 1'b0;
      rq0_ack    <= 1'b0;
      rq1_ack    <= 1'b0;
      rq0_rdata  <= 8'h00;
      rq1_rdata  <= 8'h00;
      bank_addr  <= '0;
      bank_wdata <= 8'h00;
      bank_wbe   <= 1'b0;
      bank_tog   <= 1'b0;
    end else begin
      rq0_ack    <= 1'b0;
      rq1_ack    <= 1'b0;
      bank_wbe   <= 1'b0;
      bank_tog   <= 1'b0;
      bank_wdata <= 8'h00;
      case (r_state)
        S_IDLE: begin
          if (rq0_req || rq1_req) begin
            r_gnt     <= w_gnt;
            r_last    <= w_gnt;
            r_op      <= w_gnt ? rq1_op    : rq0_op;
            r_wdata   <= w_gnt ? rq1_wdata : rq0_wdata;
            bank_addr <= w_gnt ? rq1_addr  : rq0_addr;
            busy      <= 1'b1;
            r_state   <= S_RD;
          end
        end
        S_RD: begin
          r_old_q <= bank_rdata;
          if (w_is_wr) begin
            bank_wbe   <= (r_op != OP_TOGGLE);
            bank_tog   <= (r_op == OP_TOGGLE);
            bank_wdata <= f_wr_data(r_op, r_wdata, bank_rdata, w_mask);
            r_state    <= S_WR;
          end else begin
            if (r_gnt) begin
              rq1_ack   <= 1'b1;
              rq1_rdata <= bank_rdata;
            end else begin
              rq0_ack   <= 1'b1;
              rq0_rdata <= bank_rdata;
            end
            r_state <= S_RESP;
          end
        end
        S_WR: begin
          if (r_gnt) begin
            rq1_ack   <= 1'b1;
            rq1_rdata <= r_old_q;
          end else begin
            rq0_ack   <= 1'b1;
            rq0_rdata <= r_old_q;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_reg_seq.sv
// Bench for io_reg_seq: register-bank model, ack scoreboard, vector table and arbitration/reset sequences.
module tb_io_reg_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rq0_req, rq1_req, rq0_ack, rq1_ack, busy, bank_wbe, bank_tog;
  logic [2:0] rq0_op, rq1_op;
  logic [5:0] rq0_addr, rq1_addr, bank_addr;
  logic [7:0] rq0_wdata, rq1_wdata, rq0_rdata, rq1_rdata, bank_wdata, bank_rdata;

  logic       f0_req, f1_req, f0_ack, f1_ack, f_busy, f_wbe, f_tog;
  logic [2:0] f0_op, f1_op;
  logic [5:0] f0_addr, f1_addr, f_addr;
  logic [7:0] f0_wdata, f1_wdata, f0_rdata, f1_rdata, f_wdata, f_rdata;

  io_reg_seq #(.P_AW(6), .P_RR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .rq0_req(rq0_req), .rq0_op(rq0_op), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_ack(rq0_ack), .rq0_rdata(rq0_rdata),
    .rq1_req(rq1_req), .rq1_op(rq1_op), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_ack(rq1_ack), .rq1_rdata(rq1_rdata),
    .busy(busy), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_wbe(bank_wbe), .bank_tog(bank_tog), .bank_rdata(bank_rdata)
  );

  io_reg_seq #(.P_AW(6), .P_RR(1'b0)) dut_f (
    .clk(clk), .rst(rst),
    .rq0_req(f0_req), .rq0_op(f0_op), .rq0_addr(f0_addr), .rq0_wdata(f0_wdata),
    .rq0_ack(f0_ack), .rq0_rdata(f0_rdata),
    .rq1_req(f1_req), .rq1_op(f1_op), .rq1_addr(f1_addr), .rq1_wdata(f1_wdata),
    .rq1_ack(f1_ack), .rq1_rdata(f1_rdata),
    .busy(f_busy), .bank_addr(f_addr), .bank_wdata(f_wdata),
    .bank_wbe(f_wbe), .bank_tog(f_tog), .bank_rdata(f_rdata)
  );

  // Register bank model; preload port has priority and is only used while the DUT is idle.
  logic [7:0] mem [0:63];
  logic       pre_we = 1'b0;
  logic [5:0] pre_addr = 6'd0;
  logic [7:0] pre_data = 8'd0;
  assign bank_rdata = mem[bank_addr];
  always @(posedge clk) begin
    if (pre_we)        mem[pre_addr]  <= pre_data;
    else if (bank_wbe) mem[bank_addr] <= bank_wdata;
    else if (bank_tog) mem[bank_addr] <= mem[bank_addr] ^ bank_wdata;
  end
  assign f_rdata = {2'b00, f_addr} ^ 8'h55;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  int viol = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {int who; logic [7:0] rdata; int cyc;} exp_t;
  typedef struct {int cyc; logic wbe; logic tog; logic [5:0] addr; logic [7:0] wd;} stb_t;
  exp_t sb[$];
  stb_t slog[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (bank_wbe || bank_tog) slog.push_back('{cyc, bank_wbe, bank_tog, bank_addr, bank_wdata});
    if (bank_wbe && bank_tog) viol++;
    if (!bank_wbe && !bank_tog && bank_wdata != 8'h00) viol++;
    if (rq0_ack && rq1_ack) viol++;
    if (f0_ack && f1_ack) viol++;
    if (f_wbe || f_tog || f_wdata != 8'h00) viol++;
    if (rq0_ack || rq1_ack) begin
      if (sb.size() == 0) chk("unexpected_ack", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("ack_who", rq1_ack ? 1 : 0, mon_e.who);
        chk("ack_rdata", int'(rq1_ack ? rq1_rdata : rq0_rdata), int'(mon_e.rdata));
        chk("ack_cycle", cyc, mon_e.cyc);
      end
    end
  end

  typedef struct {
    logic who; logic [2:0] op; logic [5:0] addr; logic [7:0] wd; logic [7:0] init;
    logic wbe; logic tog; logic [7:0] bwd; logic [7:0] fin;
  } vec_t;
  vec_t vt[10];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic drive(input logic who, input logic [2:0] op, input logic [5:0] a,
                       input logic [7:0] d, input logic req);
    if (who) begin rq1_req = req; rq1_op = op; rq1_addr = a; rq1_wdata = d; end
    else     begin rq0_req = req; rq0_op = op; rq0_addr = a; rq0_wdata = d; end
  endtask

  task automatic do_txn(input vec_t v);
    int c;
    bit got;
    bit wr;
    wr = v.wbe | v.tog;
    preload(v.addr, v.init);
    c = cyc;
    drive(v.who, v.op, v.addr, v.wd, 1'b1);
    sb.push_back('{int'(v.who), v.init, c + (wr ? 3 : 2)});
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (cyc == c + 1) chk("busy_rd", int'(busy), 1);
      if (sb.size() == 0) got = 1'b1;
    end
    drive(v.who, 3'd0, 6'd0, 8'd0, 1'b0);
    if (!got) begin chk("ack_timeout", 0, 1); sb.delete(); end
    tick();
    chk("busy_idle", int'(busy), 0);
    if (wr) begin
      chk("strobe_count", slog.size(), 1);
      if (slog.size() == 1) begin
        chk("strobe_cycle", slog[0].cyc, c + 2);
        chk("strobe_wbe", int'(slog[0].wbe), int'(v.wbe));
        chk("strobe_tog", int'(slog[0].tog), int'(v.tog));
        chk("strobe_addr", int'(slog[0].addr), int'(v.addr));
        chk("strobe_wdata", int'(slog[0].wd), int'(v.bwd));
      end
    end else chk("strobe_count", slog.size(), 0);
    slog.delete();
    chk("bank_final", int'(mem[v.addr]), int'(v.fin));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit got;
    vt[0] = '{1'b0, 3'd0, 6'h05, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00, 8'hA5};
    vt[1] = '{1'b1, 3'd1, 6'h10, 8'h3C, 8'h00, 1'b1, 1'b0, 8'h3C, 8'h3C};
    vt[2] = '{1'b0, 3'd3, 6'h07, 8'h06, 8'h01, 1'b1, 1'b0, 8'h41, 8'h41};
    vt[3] = '{1'b0, 3'd4, 6'h07, 8'h00, 8'h41, 1'b1, 1'b0, 8'h40, 8'h40};
    vt[4] = '{1'b1, 3'd2, 6'h20, 8'h81, 8'h0F, 1'b0, 1'b1, 8'h81, 8'h8E};
    vt[5] = '{1'b0, 3'd3, 6'h03, 8'hF9, 8'h00, 1'b1, 1'b0, 8'h02, 8'h02};
    vt[6] = '{1'b1, 3'd4, 6'h3F, 8'h0F, 8'hFF, 1'b1, 1'b0, 8'h7F, 8'h7F};
    vt[7] = '{1'b0, 3'd5, 6'h09, 8'hFF, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h5A};
    vt[8] = '{1'b1, 3'd7, 6'h09, 8'h00, 8'h33, 1'b0, 1'b0, 8'h00, 8'h33};
    vt[9] = '{1'b1, 3'd0, 6'h3F, 8'h00, 8'hC3, 1'b0, 1'b0, 8'h00, 8'hC3};

    rst = 1'b1;
    drive(1'b0, 3'd0, 6'd0, 8'd0, 1'b0);
    drive(1'b1, 3'd0, 6'd0, 8'd0, 1'b0);
    f0_req = 1'b0; f0_op = 3'd0; f0_addr = 6'd0; f0_wdata = 8'd0;
    f1_req = 1'b0; f1_op = 3'd0; f1_addr = 6'd0; f1_wdata = 8'd0;
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_acks", int'({rq0_ack, rq1_ack}), 0);
    chk("rst_rdata", int'({rq0_rdata, rq1_rdata}), 0);
    chk("rst_bank", int'({bank_addr, bank_wdata, bank_wbe, bank_tog}), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) do_txn(vt[i]);
    chk("rq0_rdata_hold", int'(rq0_rdata), 8'h5A);

    // Round-robin: both requesters hold READs; grants must alternate starting with rq0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    preload(6'd1, 8'hAA);
    preload(6'd2, 8'hBB);
    c = cyc;
    drive(1'b0, 3'd0, 6'd1, 8'd0, 1'b1);
    drive(1'b1, 3'd0, 6'd2, 8'd0, 1'b1);
    for (int i = 0; i < 6; i++) sb.push_back('{i % 2, (i % 2) ? 8'hBB : 8'hAA, c + 2 + 3 * i});
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      tick();
      if (sb.size() == 0) got = 1'b1;
    end
    drive(1'b0, 3'd0, 6'd0, 8'd0, 1'b0);
    drive(1'b1, 3'd0, 6'd0, 8'd0, 1'b0);
    if (!got) begin chk("rr_timeout", 0, 1); sb.delete(); end
    repeat (4) tick();
    chk("rr_no_strobe", slog.size(), 0);

    // Fixed priority: rq0 keeps winning while it holds req; rq1 only after rq0 drops.
    f0_req = 1'b1; f0_addr = 6'd3;
    f1_req = 1'b1; f1_addr = 6'd4;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k <= 9) begin
        chk("fp_ack0", int'(f0_ack), (k % 3 == 2) ? 1 : 0);
        chk("fp_ack1", int'(f1_ack), 0);
        if (k % 3 == 2) chk("fp_rdata0", int'(f0_rdata), 8'h56);
        if (k == 9) f0_req = 1'b0;
      end else if (k == 11) begin
        chk("fp_ack1_late", int'(f1_ack), 1);
        chk("fp_rdata1", int'(f1_rdata), 8'h51);
        chk("fp_ack0_late", int'(f0_ack), 0);
        f1_req = 1'b0;
      end
    end

    // Reset during the WR cycle of a SETB: transaction abandoned, then rq1 served normally.
    preload(6'd4, 8'h00);
    c = cyc;
    drive(1'b0, 3'd3, 6'd4, 8'h02, 1'b1);
    tick();
    tick();
    chk("rstwr_in_wr", int'(bank_wbe), 1);
    rst = 1'b1;
    drive(1'b0, 3'd0, 6'd0, 8'd0, 1'b0);
    tick();
    chk("rstwr_busy", int'(busy), 0);
    chk("rstwr_strobes", int'({bank_wbe, bank_tog}), 0);
    chk("rstwr_bank", int'({bank_addr, bank_wdata}), 0);
    chk("rstwr_acks", int'({rq0_ack, rq1_ack}), 0);
    chk("rstwr_rdata", int'({rq0_rdata, rq1_rdata}), 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("rstwr_strobe_log", slog.size(), 1);
    slog.delete();
    do_txn('{1'b1, 3'd0, 6'h11, 8'h00, 8'h77, 1'b0, 1'b0, 8'h00, 8'h77});

    chk("invariants", viol, 0);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
